// File: rtl/pll_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_seq_pkg
// Description : Shared types and helpers for the PLL lock sequencer.
//               - state_e   : sequencer state encoding (3 bits)
//               - RETRY_W   : width of the retry counter
//               - cnt_width : width needed to hold max(a, b)
// Revision    : 1.0 - initial release
// ============================================================================
package pll_seq_pkg;

    localparam int RETRY_W = 3;

    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_e;

    // Bits needed for a counter that must reach max(a, b) inclusive.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_lock_sequencer_sync_bit.sv
`default_nettype none
// ============================================================================
// Module      : sync_bit
// Description : Single-bit multi-flop synchronizer, async active-high reset
//               clears the whole chain to 0.
// Ports       : clk  - destination clock
//               rst  - asynchronous active-high reset
//               d    - asynchronous input bit
//               q    - synchronized output (SYNC_STAGES cycles of latency)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = r_chain[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_sequencer
// Description : Sequences the PLL reset, qualifies lock, and holds the core
//               in reset until lock has been stable. Re-locks on lock loss or
//               on request; gives up into FAULT after repeated timeouts.
//               Runs entirely on the board reference clock.
// Ports       : refclk      - 50 MHz reference clock
//               rst         - asynchronous active-high reset
//               locked      - PLL lock, asynchronous to refclk
//               relock_req  - level re-lock request; also the FAULT exit
//               pll_rst     - PLL reset, active high
//               sys_reset   - core reset, active high
//               ready       - high only in RUN
//               retry_count - timeouts since last RUN entry, saturating
//               fault       - high only in FAULT
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 50000,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int SYNC_STAGES        = 2,
    parameter int MAX_RETRIES        = 7
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               locked,
    input  logic               relock_req,
    output logic               pll_rst,
    output logic               sys_reset,
    output logic               ready,
    output logic [RETRY_W-1:0] retry_count,
    output logic               fault
);

    localparam int CNT_W = cnt_width(LOCK_TIMEOUT, PLL_RST_CYCLES);
    localparam int STB_W = cnt_width(LOCK_STABLE_CYCLES, 1);

    localparam logic [2:0] c_ST_PLL_RESET = PLL_RESET;
    localparam logic [2:0] c_ST_WAIT_LOCK = WAIT_LOCK;
    localparam logic [2:0] c_ST_STABILIZE = STABILIZE;
    localparam logic [2:0] c_ST_RUN       = RUN;
    localparam logic [2:0] c_ST_FAULT     = FAULT;

    localparam logic [CNT_W-1:0]   c_RST_LAST   = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_TMO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_W-1:0]   c_STB_DONE   = STB_W'(LOCK_STABLE_CYCLES);
    localparam logic [RETRY_W-1:0] c_RETRY_MAX  = RETRY_W'(MAX_RETRIES);
    localparam logic [RETRY_W-1:0] c_RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);

    // ------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------
    logic [2:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [STB_W-1:0]   r_stable;
    logic [RETRY_W-1:0] r_retry;
    logic               r_lost;      // locked_s was low last cycle while in RUN
    logic               r_relock_d;  // previous relock_req, for edge detect

    logic [2:0]         w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [STB_W-1:0]   w_stable_nxt;
    logic [RETRY_W-1:0] w_retry_nxt;
    logic               w_lost_nxt;
    logic               w_locked_s;
    logic               w_timeout;
    logic               w_retry_ok;
    logic               w_relock_rise;

    // ------------------------------------------------------------------
    // Lock synchronizer: the only consumer of raw `locked`
    // ------------------------------------------------------------------
    sync_bit #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (locked),
        .q   (w_locked_s)
    );

    assign w_timeout     = (r_cnt == c_TMO_LAST);
    // retry_count + 1 < MAX_RETRIES, written without the extra carry bit
    assign w_retry_ok    = (r_retry < c_RETRY_LAST);
    assign w_relock_rise = relock_req & ~r_relock_d;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_stable_nxt = r_stable;
        w_retry_nxt  = r_retry;
        w_lost_nxt   = 1'b0;

        case (r_state)
            c_ST_PLL_RESET: begin
                // relock_req deliberately ignored here
                if (r_cnt == c_RST_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_WAIT_LOCK;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            c_ST_WAIT_LOCK: begin
                w_stable_nxt = '0;
                // Timeout wins over a coincident lock so the shared counter
                // can never run past its terminal value.
                if (w_timeout) begin
                    w_cnt_nxt = '0;
                    if (w_retry_ok) begin
                        w_retry_nxt = r_retry + 1'b1;
                        w_state_nxt = c_ST_PLL_RESET;
                    end else begin
                        w_retry_nxt = c_RETRY_MAX;
                        w_state_nxt = c_ST_FAULT;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (w_locked_s) begin
                        w_stable_nxt = STB_W'(1);
                        w_state_nxt  = c_ST_STABILIZE;
                    end
                end
            end

            c_ST_STABILIZE: begin
                if (r_stable == c_STB_DONE) begin
                    // Qualified lock beats a timeout landing on the same edge
                    w_state_nxt  = c_ST_RUN;
                    w_cnt_nxt    = '0;
                    w_stable_nxt = '0;
                    w_retry_nxt  = '0;
                end else if (w_timeout) begin
                    w_cnt_nxt    = '0;
                    w_stable_nxt = '0;
                    if (w_retry_ok) begin
                        w_retry_nxt = r_retry + 1'b1;
                        w_state_nxt = c_ST_PLL_RESET;
                    end else begin
                        w_retry_nxt = c_RETRY_MAX;
                        w_state_nxt = c_ST_FAULT;
                    end
                end else begin
                    // Timeout keeps running across WAIT_LOCK/STABILIZE bounces,
                    // so a chattering lock ends in a retry rather than looping.
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (w_locked_s) begin
                        w_stable_nxt = r_stable + 1'b1;
                    end else begin
                        w_stable_nxt = '0;
                        w_state_nxt  = c_ST_WAIT_LOCK;
                    end
                end
            end

            c_ST_RUN: begin
                w_lost_nxt = ~w_locked_s;
                // Two consecutive low samples count as lock loss; a single
                // dropout only arms r_lost. A request and a loss together
                // still produce a single PLL_RESET entry.
                if (relock_req || (~w_locked_s && r_lost)) begin
                    w_state_nxt = c_ST_PLL_RESET;
                    w_cnt_nxt   = '0;
                    w_lost_nxt  = 1'b0;
                end
            end

            c_ST_FAULT: begin
                if (w_relock_rise) begin
                    w_retry_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_PLL_RESET;
                end
            end

            default: begin
                w_state_nxt  = c_ST_PLL_RESET;
                w_cnt_nxt    = '0;
                w_stable_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered outputs. Outputs are decoded from the next
    // state so they change on the same edge as the state itself.
    // ------------------------------------------------------------------
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_PLL_RESET;
            r_cnt      <= '0;
            r_stable   <= '0;
            r_retry    <= '0;
            r_lost     <= 1'b0;
            r_relock_d <= 1'b0;
            pll_rst    <= 1'b1;
            sys_reset  <= 1'b1;
            ready      <= 1'b0;
            fault      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_stable   <= w_stable_nxt;
            r_retry    <= w_retry_nxt;
            r_lost     <= w_lost_nxt;
            r_relock_d <= relock_req;
            pll_rst    <= (w_state_nxt == c_ST_PLL_RESET) || (w_state_nxt == c_ST_FAULT);
            sys_reset  <= (w_state_nxt != c_ST_RUN);
            ready      <= (w_state_nxt == c_ST_RUN);
            fault      <= (w_state_nxt == c_ST_FAULT);
        end
    end

    assign retry_count = r_retry;

endmodule
`default_nettype wire

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Drives the PLL wrapper's `rst` input and consumes its `locked` output.
- Sequences PLL reset and qualifies lock before releasing the core.
- Holds the system reset asserted until lock has been stable; re-locks on lock loss or on a relock request (e.g. video mode change).
- Runs on the 50 MHz board reference clock, because the PLL output clocks are not valid while unlocked.

Parameters:
- PLL_RST_CYCLES, 16: refclk cycles `pll_rst` is held high per reset attempt (min 1).
- LOCK_TIMEOUT, 50000: refclk cycles allowed from `pll_rst` release to qualified lock (1 ms).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-`locked` high cycles required before release.
- SYNC_STAGES, 2: flop stages on the `locked` synchronizer (min 2).
- MAX_RETRIES, 7: timeouts tolerated before entering FAULT (1..7).

Ports:
- refclk  in  1  50 MHz reference clock; all logic is on this clock.
- rst  in  1  asynchronous active-high reset.
- locked  in  1  PLL lock indication, asynchronous to refclk.
- relock_req  in  1  level request for a full PLL re-lock; also the only exit from FAULT.
- pll_rst  out  1  reset to the PLL, active high.
- sys_reset  out  1  core reset, active high, registered.
- ready  out  1  high only in RUN.
- retry_count  out  3  timeouts since last RUN entry, saturating.
- fault  out  1  high only in FAULT.

Behaviour:
- Reset values (all outputs registered, async reset): pll_rst=1, sys_reset=1, ready=0, retry_count=0, fault=0, state=PLL_RESET, all counters 0.
- `locked` passes through the SYNC_STAGES synchronizer, giving locked_s. The synchronizer resets to 0. No other logic samples raw `locked`.
- One shared counter `cnt` is sized $clog2(max(LOCK_TIMEOUT, PLL_RST_CYCLES)+1). A separate stable counter is sized $clog2(LOCK_STABLE_CYCLES+1).
- PLL_RESET:
  - pll_rst=1, sys_reset=1.
  - `cnt` increments each cycle.
  - At cnt==PLL_RST_CYCLES-1: clear `cnt`, go to WAIT_LOCK.
  - relock_req has no effect in this state.
- WAIT_LOCK:
  - pll_rst=0.
  - `cnt` counts the timeout and is shared with STABILIZE (not cleared between them).
  - locked_s=1: go to STABILIZE with stable=1.
  - Timeout (cnt==LOCK_TIMEOUT-1):
    - If retry_count+1 < MAX_RETRIES: increment retry_count, go to PLL_RESET.
    - Otherwise: retry_count=MAX_RETRIES, go to FAULT.
- STABILIZE:
  - locked_s=1: stable increments.
  - When stable reaches LOCK_STABLE_CYCLES: go to RUN. This has priority over a timeout in the same cycle.
  - locked_s=0: stable=0, return to WAIT_LOCK. The timeout keeps running, so glitchy lock ends in a retry, not a livelock.
- RUN:
  - On entry: sys_reset=0, ready=1, retry_count=0, `cnt` cleared.
  - locked_s=0 for 2 consecutive cycles: go to PLL_RESET.
    - sys_reset=1 and ready=0 from the next cycle.
    - A single-cycle dropout is ignored.
    - Lock loss does not increment retry_count.
  - relock_req=1: go to PLL_RESET. If relock_req and lock loss occur in the same cycle, the result is one PLL_RESET, no increment.
- FAULT:
  - pll_rst=1, sys_reset=1, fault=1.
  - A rising edge of relock_req (registered edge detect) clears retry_count and fault and goes to PLL_RESET.
- sys_reset is high in every state except RUN. ready == (state==RUN). Both change on the same edge.
- Async `rst` mid-operation immediately returns all outputs to their reset values, including pll_rst=1.
- Latency: ready rises at edge L+SYNC_STAGES+LOCK_STABLE_CYCLES, where L is the first refclk edge sampling locked=1, provided lock stays high and no timeout occurs.

Decomposition:
- Package pll_seq_pkg holds:
  - state enum {PLL_RESET, WAIT_LOCK, STABILIZE, RUN, FAULT}, 3-bit encoded;
  - the RETRY_W=3 constant;
  - a counter-width function.
- One sub-module, sync_bit: parameterized SYNC_STAGES flop chain with async active-high reset to 0, instanced for `locked`.

Test Plan:
All scenarios use PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE_CYCLES=8, SYNC_STAGES=2, MAX_RETRIES=3.
- Clean bring-up: release rst at edge 0, raise locked at edge 10 -> pll_rst high edges 0-3 and low from edge 4; ready=1 and sys_reset=0 at edge 20; retry_count=0.
- Glitch in STABILIZE: drop locked for 1 cycle after 5 stable cycles, then hold high -> stable restarts; ready does not rise before 8 consecutive locked_s-high cycles; no retry if within the timeout.
- Timeout retries to fault: locked never asserts -> retry_count steps 1, 2; third timeout gives fault=1, retry_count=3, pll_rst=1. Then pulse relock_req -> fault=0, retry_count=0, PLL_RESET for 4 cycles.
- Lock loss in RUN: 1-cycle locked drop -> ready stays 1. 2-cycle drop -> sys_reset=1 two edges after locked_s falls, then pll_rst=1 for 4 cycles; retry_count unchanged.
- relock_req in RUN coinciding with lock loss -> exactly one 4-cycle pll_rst pulse; retry_count=0.
- Async rst asserted mid-STABILIZE (between edges) -> pll_rst=1, sys_reset=1, ready=0 immediately; normal bring-up resumes after release.
